// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding,
// counter sizing and the bit-order selection used by the shift register.
package serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    localparam int MAX_WIDTH     = 32;
    localparam int IDX_W         = $clog2(MAX_WIDTH);
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Bit that leaves the shifter next, given the word's width and bit order.
    function automatic logic next_bit(input logic [MAX_WIDTH-1:0] word,
                                      input int                   width,
                                      input logic                 msb_first);
        return msb_first ? word[IDX_W'(width - 1)] : word[0];
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load / serial-shift register; MSB_FIRST selects which
// end of the word leaves first.
module piso_shift_reg
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0]     sreg_q;
    logic [WIDTH-1:0]     sreg_d;
    logic [MAX_WIDTH-1:0] sreg_ext;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // NOTE: pure datapath, no reset -- the owner's FSM masks the contents until a load.
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
    end

    assign sreg_ext = MAX_WIDTH'(sreg_q);
    assign bit_o    = next_bit(sreg_ext, WIDTH, MSB_FIRST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one bit per clock out,
// with a one-word holding register so consecutive words stream without gaps.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             restn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             first_bit,
    output logic             busy
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   hold_q, hold_d;

    logic               accept;
    logic               sh_load, sh_shift, sh_bit;
    logic [WIDTH-1:0]   sh_data;

    assign data_ready = !hold_full_q;
    assign accept     = data_valid && data_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_data     = data_in;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word follows the last bit directly, keeping the stream gapless.
                    sh_load     = 1'b1;
                    sh_data     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (sh_data),
        .bit_o   (sh_bit)
    );

    assign serial_valid = (state_q == S_SHIFT);
    assign first_bit    = serial_valid && (cnt_q == '0);
    assign serial_out   = serial_valid ? sh_bit : IDLE_LEVEL;
    assign busy         = serial_valid || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance run in lockstep
// against a bit-queue model of the serial stream.
module tb_bit_serializer;

    localparam int WIDTH      = 8;
    localparam bit IDLE_LEVEL = 1'b0;

    logic clk = 1'b0;
    logic restn;

    logic [WIDTH-1:0] data_m, data_l;
    logic             valid_m, valid_l;
    logic             dr_m, so_m, sv_m, fb_m, bz_m;
    logic             dr_l, so_l, sv_l, fb_l, bz_l;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected stream per lane: {first_bit, serial bit}, one entry per clock.
    logic [1:0] mq[$];
    logic [1:0] lq[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LEVEL)) dut_m (
        .clk          (clk),
        .restn        (restn),
        .data_in      (data_m),
        .data_valid   (valid_m),
        .data_ready   (dr_m),
        .serial_out   (so_m),
        .serial_valid (sv_m),
        .first_bit    (fb_m),
        .busy         (bz_m)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LEVEL)) dut_l (
        .clk          (clk),
        .restn        (restn),
        .data_in      (data_l),
        .data_valid   (valid_l),
        .data_ready   (dr_l),
        .serial_out   (so_l),
        .serial_valid (sv_l),
        .first_bit    (fb_l),
        .busy         (bz_l)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string nm,
                              input logic so, input logic sv, input logic fb,
                              input logic dr, input logic bz,
                              input logic e_so, input logic e_sv, input logic e_fb,
                              input logic e_dr);
        check({nm, ".serial_out"},   so, e_so);
        check({nm, ".serial_valid"}, sv, e_sv);
        check({nm, ".first_bit"},    fb, e_fb);
        check({nm, ".data_ready"},   dr, e_dr);
        check({nm, ".busy"},         bz, e_sv);
    endtask

    task automatic check_reset_outputs(input string nm);
        check_lane({nm, ".m"}, so_m, sv_m, fb_m, dr_m, bz_m, IDLE_LEVEL, 1'b0, 1'b0, 1'b1);
        check_lane({nm, ".l"}, so_l, sv_l, fb_l, dr_l, bz_l, IDLE_LEVEL, 1'b0, 1'b0, 1'b1);
    endtask

    // One clock: decide acceptance from the model's own occupancy, append
    // accepted words to the expected stream, then compare one bit per lane.
    task automatic step();
        logic             acc_m, acc_l, vm, vl;
        logic [1:0]       em, el;
        logic [WIDTH-1:0] w;
        acc_m = valid_m && (mq.size() < WIDTH);
        acc_l = valid_l && (lq.size() < WIDTH);
        @(posedge clk);
        if (acc_m) begin
            w = data_m;
            for (int i = 0; i < WIDTH; i++) begin
                mq.push_back({(i == 0), w[WIDTH-1]});
                w = w << 1;
            end
        end
        if (acc_l) begin
            w = data_l;
            for (int i = 0; i < WIDTH; i++) begin
                lq.push_back({(i == 0), w[0]});
                w = w >> 1;
            end
        end
        #1;
        vm = (mq.size() > 0);
        em = vm ? mq.pop_front() : {1'b0, IDLE_LEVEL};
        vl = (lq.size() > 0);
        el = vl ? lq.pop_front() : {1'b0, IDLE_LEVEL};
        check_lane("msb", so_m, sv_m, fb_m, dr_m, bz_m, em[0], vm, em[1], mq.size() < WIDTH);
        check_lane("lsb", so_l, sv_l, fb_l, dr_l, bz_l, el[0], vl, el[1], lq.size() < WIDTH);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        restn   = 1'b0;
        valid_m = 1'b0;
        valid_l = 1'b0;
        data_m  = '0;
        data_l  = '0;

        // Reset held for five clocks.
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Single word 8'hD6, offered on the first edge after release.
        @(negedge clk);
        restn   = 1'b1;
        valid_m = 1'b1;
        data_m  = 8'hD6;
        step();
        valid_m = 1'b0;
        steps(10);

        // Back-to-back B5 then 2A: second word is held, stream is gapless.
        valid_m = 1'b1;
        data_m  = 8'hB5;
        step();
        data_m  = 8'h2A;
        step();
        valid_m = 1'b0;
        data_m  = 8'hFF;
        steps(18);

        // LSB-first lane: 8'h01.
        valid_l = 1'b1;
        data_l  = 8'h01;
        step();
        valid_l = 1'b0;
        steps(10);

        // Backpressure: valid held high with changing data while the holding word waits.
        valid_m = 1'b1;
        valid_l = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_m = WIDTH'($urandom);
            data_l = WIDTH'($urandom);
            step();
        end
        valid_m = 1'b0;
        valid_l = 1'b0;
        steps(20);

        // Reset mid-word with a held word pending: outputs drop before the next edge.
        valid_m = 1'b1;
        data_m  = WIDTH'($urandom);
        valid_l = 1'b1;
        data_l  = WIDTH'($urandom);
        step();
        data_m  = WIDTH'($urandom);
        data_l  = WIDTH'($urandom);
        step();
        valid_m = 1'b0;
        valid_l = 1'b0;
        steps(2);
        #2;
        restn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mq.delete();
        lq.delete();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        @(negedge clk);
        restn = 1'b1;
        steps(3);

        // Randomized traffic with sporadic valid.
        for (int i = 0; i < 400; i++) begin
            valid_m = ($urandom_range(0, 3) != 0);
            valid_l = ($urandom_range(0, 2) == 0);
            data_m  = WIDTH'($urandom);
            data_l  = WIDTH'($urandom);
            step();
        end
        valid_m = 1'b0;
        valid_l = 1'b0;
        steps(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the Moore pattern detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `serial_out`, which drives the detector's `in`. A one-word holding register lets back-to-back words stream with no idle bit between them, so patterns that span word boundaries reach the detector intact.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `serial_out` when no word is shifting.

Ports:
- `clk` in 1: single clock, rising edge.
- `restn` in 1: reset, asynchronous, active-low.
- `data_in` in WIDTH: parallel word; sampled only on an accepted handshake.
- `data_valid` in 1: upstream offers `data_in`.
- `data_ready` out 1: block can accept a word this cycle.
- `serial_out` out 1: current serial bit (registered); connects to detector `in`.
- `serial_valid` out 1: `serial_out` carries a data bit this cycle.
- `first_bit` out 1: high during the first bit of each word.
- `busy` out 1: shifter active or holding register full.

## Operation
- Handshake: a word is accepted on a rising edge where `data_valid && data_ready`. `data_ready` = holding register empty, as a combinational decode of registered state.
- Storage: a shift register with bit counter `cnt` (width $clog2(WIDTH)), plus a holding register with flag `hold_full`.
- States: S_IDLE (shifter empty), S_SHIFT (shifter emitting bits).
- S_IDLE, accept: word loads directly into the shifter, `cnt`=0, go to S_SHIFT. The first bit appears on `serial_out` from that edge.
- S_SHIFT, `cnt` < WIDTH-1: advance one bit, `cnt`++. An accept in this state goes to the holding register and sets `hold_full`.
- S_SHIFT, `cnt` == WIDTH-1 (last bit):
  - If `hold_full`: load the holding word into the shifter, clear `hold_full`, `cnt`=0, stay in S_SHIFT (gapless).
  - Else if an accept occurs on this edge: the new word loads straight into the shifter and the FSM stays in S_SHIFT.
  - Else: go to S_IDLE.
- `serial_valid` = (state == S_SHIFT).
- `first_bit` = S_SHIFT && `cnt`==0.
- `serial_out` = IDLE_LEVEL in S_IDLE.
- `busy` = S_SHIFT || `hold_full`.
- `data_in` is ignored when not accepted. `data_valid` may drop at any time without consequence.

## Timing
- Reset values, all asynchronous on `restn` low:
  - state S_IDLE, `cnt`=0, `hold_full`=0.
  - `serial_out`=IDLE_LEVEL, `serial_valid`=0, `first_bit`=0, `busy`=0, `data_ready`=1.
- Latency: accept at edge N means bit 0 of the order is valid after edge N. The last bit is valid after edge N+WIDTH-1.
- Throughput: one bit per clock. Continuous words run with zero gap when the holding register is filled before the current word's last bit.
- `data_ready` drops the cycle after the holding register fills. It rises the cycle after the holding word transfers to the shifter.
- No accept is possible with `hold_full`=1, so the block never overwrites a held word.
- Reset mid-word: the partial word and the held word are discarded. Output returns to IDLE_LEVEL immediately; no bit is emitted after `restn` falls.
- Reset release: the first acceptable edge is the first rising edge with `restn` high.

## Structure
- Package `serializer_pkg`:
  - state enum {S_IDLE, S_SHIFT}.
  - localparam for counter width derived from WIDTH.
  - bit-order helper function returning the next bit under MSB_FIRST.
- Sub-module `piso_shift_reg`: WIDTH-bit load/shift register with a direction parameter. The top block holds the FSM, the holding register and the handshake.

## Test plan
- Reset: hold `restn`=0 for 5 clocks.
  - Expect `serial_out`=0, `serial_valid`=0, `data_ready`=1, `busy`=0.
  - Assert `restn` low mid-shift; expect all outputs back to reset values before the next edge.
- Single word: WIDTH=8, MSB_FIRST=1, send 8'hD6.
  - Expect `serial_out` 1,1,0,1,0,1,1,0 on 8 consecutive cycles.
  - `first_bit` high only on the first cycle; `serial_valid` high exactly 8 cycles; then IDLE_LEVEL.
- Back-to-back: keep `data_valid`=1 with words 8'hB5 then 8'h2A.
  - Expect 16 contiguous valid bits 10110101 00101010 with no gap.
  - `data_ready` low while the second word is held.
- LSB order: MSB_FIRST=0, send 8'h01. Expect 1,0,0,0,0,0,0,0.
- Backpressure: drive `data_valid` continuously with a changing `data_in` while `hold_full`=1.
  - Expect no accept and the held value unchanged.
  - The next accept occurs only after `data_ready` returns high.
- Detector integration: chain with `pattern_detector_Moore` and stream 8'hD6, 8'hB5.
  - Expect the detector output to match a reference model fed the same 16-bit sequence, including matches spanning the word boundary.
